// File: rtl/web_pkg.sv
// Shared definitions for the web-shooter selection front end: choice indices,
// FSM state encoding and the select-code helpers.
package web_pkg;

    localparam int WEB_N = 8;

    // Choice index; button bit position is (WEB_N-1 - index).
    localparam logic [2:0] CHOICE_SWING    = 3'd0;
    localparam logic [2:0] CHOICE_ZIP      = 3'd1;
    localparam logic [2:0] CHOICE_NET      = 3'd2;
    localparam logic [2:0] CHOICE_SPLIT    = 3'd3;
    localparam logic [2:0] CHOICE_TASER    = 3'd4;
    localparam logic [2:0] CHOICE_IMPACT   = 3'd5;
    localparam logic [2:0] CHOICE_RICOCHET = 3'd6;
    localparam logic [2:0] CHOICE_RELOAD   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_RELEASE  = 2'd3
    } web_state_e;

    // The decoder downstream expects the choice index with its bits reversed.
    function automatic logic [2:0] web_sel_encode(input logic [2:0] idx);
        return {idx[0], idx[1], idx[2]};
    endfunction

    // Highest button bit wins: swing line outranks everything, reload is last.
    function automatic logic [2:0] web_prio_idx(input logic [WEB_N-1:0] req);
        logic [2:0] idx;
        idx = CHOICE_SWING;
        if      (req[7]) idx = CHOICE_SWING;
        else if (req[6]) idx = CHOICE_ZIP;
        else if (req[5]) idx = CHOICE_NET;
        else if (req[4]) idx = CHOICE_SPLIT;
        else if (req[3]) idx = CHOICE_TASER;
        else if (req[2]) idx = CHOICE_IMPACT;
        else if (req[1]) idx = CHOICE_RICOCHET;
        else if (req[0]) idx = CHOICE_RELOAD;
        return idx;
    endfunction

    // More than one button in the accepted pattern.
    function automatic logic web_multi(input logic [WEB_N-1:0] req);
        logic [WEB_N-1:0] one_less;
        one_less = req - {{(WEB_N-1){1'b0}}, 1'b1};
        return (req & one_less) != '0;
    endfunction

endpackage

// File: rtl/web_req_debounce.sv
// Button synchroniser plus capture/stability counter. The owning FSM tells this
// block whether it is idle (arm on any press) or debouncing (track the pattern).
module web_req_debounce
    import web_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WEB_N-1:0] web_req,
    input  logic             in_idle,
    input  logic             in_debounce,
    output logic [WEB_N-1:0] req_sync,
    output logic [WEB_N-1:0] stable_req,
    output logic             stable_pulse
);

    logic [WEB_N-1:0] meta;
    logic [CNT_W-1:0] cnt;
    logic             req_any;
    logic             req_match;

    assign req_any   = req_sync != '0;
    assign req_match = req_sync == stable_req;

    // Two-flop synchroniser; everything downstream looks only at req_sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            req_sync <= '0;
        end else begin
            meta     <= web_req;
            req_sync <= meta;
        end
    end

    // Capture a new pattern (fresh press or changed pattern) and count down
    // while it holds; terminal count zero means DEBOUNCE_CYCLES matching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_req <= '0;
            cnt        <= '0;
        end else if (req_any && (in_idle || (in_debounce && !req_match))) begin
            stable_req <= req_sync;
            cnt        <= CNT_W'(DEBOUNCE_CYCLES - 1);
        end else if (in_debounce && req_any && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign stable_pulse = in_debounce && req_any && req_match && (cnt == '0);

endmodule

// File: rtl/web_select_encoder.sv
// Web-request front end: debounced, priority-resolved button press presented as
// a bit-reversed select code with enable, held until the dispatcher acks, then
// re-armed only once every button is released.
//
// state    | meaning
// IDLE     | no button seen, waiting for any press
// DEBOUNCE | pattern captured, counting stable samples
// PRESENT  | select/enable driven, waiting for ack
// RELEASE  | handshake done, waiting for all buttons up
module web_select_encoder
    import web_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WEB_N-1:0] web_req,
    input  logic             ack,
    output logic [2:0]       select,
    output logic             enable,
    output logic             multi_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    web_state_e       state;
    logic [WEB_N-1:0] req_sync;
    logic [WEB_N-1:0] stable_req;
    logic             stable_pulse;
    logic             req_any;

    assign req_any = req_sync != '0;

    web_req_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .web_req      (web_req),
        .in_idle      (state == ST_IDLE),
        .in_debounce  (state == ST_DEBOUNCE),
        .req_sync     (req_sync),
        .stable_req   (stable_req),
        .stable_pulse (stable_pulse)
    );

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            select    <= 3'b000;
            enable    <= 1'b0;
            multi_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        state <= ST_DEBOUNCE;
                        busy  <= 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (stable_pulse) begin
                        select    <= web_sel_encode(web_prio_idx(stable_req));
                        multi_err <= web_multi(stable_req);
                        enable    <= 1'b1;
                        state     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        enable    <= 1'b0;
                        multi_err <= 1'b0;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_web_select_encoder.sv
// Bench for web_select_encoder: expected presentations are queued as presses
// are driven and checked when enable rises.
module tb_web_select_encoder;

    localparam int D = 16;
    localparam int LAT = D + 3;   // posedges from first sampling edge to enable seen high

    logic       clk;
    logic       rst_n;
    logic [7:0] web_req;
    logic       ack;
    logic [2:0] select;
    logic       enable;
    logic       multi_err;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int enable_pulses = 0;

    typedef struct {
        logic [2:0] sel;
        logic       merr;
    } exp_t;
    exp_t sb_q[$];

    logic en_prev = 1'b0;

    web_select_encoder #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .web_req   (web_req),
        .ack       (ack),
        .select    (select),
        .enable    (enable),
        .multi_err (multi_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: on every enable rising edge pop and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && enable && !en_prev) begin
            enable_pulses++;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_enable: select=%b multi_err=%b, none expected", select, multi_err);
            end else begin
                e = sb_q.pop_front();
                if (select !== e.sel || multi_err !== e.merr) begin
                    miscompares++;
                    $display("FAIL sb_present: select=%b multi_err=%b, expected select=%b multi_err=%b",
                             select, multi_err, e.sel, e.merr);
                end
            end
        end
        en_prev = enable;
    end

    // Reference model of the expected presentation for a button pattern.
    function automatic exp_t model(input logic [7:0] req);
        exp_t r;
        logic [2:0] idx;
        idx = 3'd0;
        for (int p = 0; p < 8; p++)
            if (req[p]) idx = 3'(7 - p);
        r.sel  = {idx[0], idx[1], idx[2]};
        r.merr = $countones(req) > 1;
        return r;
    endfunction

    // Counts posedges until enable is seen high; -1 if the budget runs out.
    task automatic wait_enable(output int edges);
        edges = -1;
        for (int i = 1; i <= 4 * D; i++) begin
            @(posedge clk);
            #2;
            if (enable === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic release_all();
        @(negedge clk);
        web_req = 8'h00;
        ack = 1'b0;
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        web_req = 8'hFF;
        ack = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (select !== 3'b000 || enable !== 1'b0 || busy !== 1'b0 || multi_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: sel=%b en=%b busy=%b merr=%b, expected 000 0 0 0",
                     select, enable, busy, multi_err);
        end
        @(negedge clk);
        web_req = 8'h00;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        vectors++;
        if (busy !== 1'b0 || enable !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_hold: busy=%b en=%b, expected 0 0", busy, enable);
        end
    endtask

    task automatic test_single_press();
        int lat;
        @(negedge clk);
        web_req = 8'b0100_0000;
        sb_q.push_back(model(8'b0100_0000));
        wait_enable(lat);
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL single_latency: edges=%0d, expected %0d", lat, LAT);
        end
        vectors++;
        if (select !== 3'b100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_select: sel=%b busy=%b, expected 100 1", select, busy);
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if (enable !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack_drop: en=%b, expected 0", enable);
        end
        @(negedge clk);
        ack = 1'b0;
        vectors++;
        if (select !== 3'b100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_hold_after_ack: sel=%b busy=%b, expected 100 1", select, busy);
        end
        release_all();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_release: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_glitch();
        int start;
        start = enable_pulses;
        @(negedge clk);
        ack = 1'b1;              // ack while enable=0 must be ignored
        web_req = 8'h01;
        repeat (D - 1) @(posedge clk);
        @(negedge clk);
        web_req = 8'h00;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_debounce_entered: busy=%b, expected 1", busy);
        end
        repeat (3 * D) @(posedge clk);
        #2;
        vectors++;
        if (enable_pulses != start || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_no_enable: pulses=%0d busy=%b, expected %0d 0",
                     enable_pulses, busy, start);
        end
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_multi_press();
        int lat;
        @(negedge clk);
        web_req = 8'b0000_0011;
        sb_q.push_back(model(8'b0000_0011));
        wait_enable(lat);
        vectors++;
        if (lat != LAT || select !== 3'b011 || multi_err !== 1'b1) begin
            miscompares++;
            $display("FAIL multi_present: edges=%0d sel=%b merr=%b, expected %0d 011 1",
                     lat, select, multi_err, LAT);
        end
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #2;
        vectors++;
        if (multi_err !== 1'b0 || enable !== 1'b0) begin
            miscompares++;
            $display("FAIL multi_after_ack: merr=%b en=%b, expected 0 0", multi_err, enable);
        end
        release_all();
    endtask

    task automatic test_no_retrigger();
        int lat;
        int start;
        start = enable_pulses;
        @(negedge clk);
        web_req = 8'h08;
        sb_q.push_back(model(8'h08));
        wait_enable(lat);
        vectors++;
        if (lat != LAT || select !== 3'b001) begin
            miscompares++;
            $display("FAIL noretrig_present: edges=%0d sel=%b, expected %0d 001", lat, select, LAT);
        end
        @(negedge clk);
        ack = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        vectors++;
        if (enable_pulses != start + 1 || enable !== 1'b0) begin
            miscompares++;
            $display("FAIL noretrig_held: pulses=%0d en=%b, expected %0d 0",
                     enable_pulses, enable, start + 1);
        end
        @(negedge clk);
        web_req = 8'h04;
        repeat (3 * D) @(posedge clk);
        #2;
        vectors++;
        if (enable_pulses != start + 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL noretrig_changed: pulses=%0d busy=%b, expected %0d 1",
                     enable_pulses, busy, start + 1);
        end
        release_all();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL noretrig_rearm: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset_in_present();
        int lat;
        @(negedge clk);
        web_req = 8'h01;
        sb_q.push_back(model(8'h01));
        wait_enable(lat);
        vectors++;
        if (lat != LAT || select !== 3'b111) begin
            miscompares++;
            $display("FAIL rst_present: edges=%0d sel=%b, expected %0d 111", lat, select, LAT);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (enable !== 1'b0 || select !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: en=%b sel=%b busy=%b, expected 0 000 0", enable, select, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(model(8'h01));
        wait_enable(lat);
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL rst_redebounce: edges=%0d, expected %0d", lat, LAT);
        end
        @(negedge clk);
        ack = 1'b1;
        release_all();
    endtask

    task automatic test_back_to_back();
        logic [7:0] pats [10];
        int lat;
        for (int i = 0; i < 8; i++) pats[i] = 8'(1 << i);
        pats[8] = 8'b1010_0000;
        pats[9] = 8'b0011_1100;
        foreach (pats[k]) begin
            exp_t e;
            e = model(pats[k]);
            @(negedge clk);
            web_req = pats[k];
            sb_q.push_back(e);
            wait_enable(lat);
            vectors++;
            if (lat != LAT || select !== e.sel) begin
                miscompares++;
                $display("FAIL b2b_%0h: edges=%0d sel=%b, expected %0d %b",
                         pats[k], lat, select, LAT, e.sel);
            end
            @(negedge clk);
            ack = 1'b1;
            release_all();
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_multi_press();
        test_no_retrigger();
        test_reset_in_present();
        test_back_to_back();
        repeat (4) @(posedge clk);
        #2;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
